hkspi_passthru_ctrl: RTL and testbench

//  Oversampled front end of the housekeeping SPI. Synchronises host CSB/SCK/SDI to the core clock and decodes the first byte of each frame.

---
 rtl/hkspi_passthru_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hkspi_passthru_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hkspi_passthru_ctrl.sv
// hkspi_passthru_ctrl: oversampled housekeeping SPI front end with flash pass-thru; define HKSPI_PASSTHRU_MGMT_EN to add the mgmt flash tunnel
module hkspi_passthru_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] USER_CMD    = 8'hC2,
  parameter logic [7:0] MGMT_CMD    = 8'hC4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hk_csb,
  input  logic       hk_sck,
  input  logic       hk_sdi,
  output logic       hk_sdo,
  output logic       hk_sdo_oe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_first,
  input  logic       reg_sdo,
  output logic       user_csb,
  output logic       user_sck,
  output logic       user_io0,
  input  logic       user_io1,
`ifdef HKSPI_PASSTHRU_MGMT_EN
  output logic       mgmt_csb,
  output logic       mgmt_sck,
  output logic       mgmt_io0,
  input  logic       mgmt_io1,
`endif
  output logic       mgmt_hold,
  output logic [1:0] pass_active
);
  typedef enum logic [2:0] {IDLE, CMD, HK, PASS_USER, PASS_MGMT} state_t;
`ifdef HKSPI_PASSTHRU_MGMT_EN
  localparam bit MGMT_EN = 1'b1;
`else
  localparam bit MGMT_EN = 1'b0;
`endif
  logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, sdi_sync_q;
  logic csb_p_q, sck_p_q;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic bv_q, bv_d, bf_q, bf_d, sdo_q, sdo_d, oe_q, oe_d, gate_q, gate_d;
  logic ucsb_q, usck_q, uio_q;
  logic [1:0] pa_q, pa_d;
  logic csb_s, sck_s, sdi_s, csb_rise, csb_fall, sck_rise, sck_fall, pass_u, pass_m, mgmt_in;
  assign csb_s = csb_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
  assign csb_rise = csb_s & ~csb_p_q;
  assign csb_fall = ~csb_s & csb_p_q;
  assign sck_rise = sck_s & ~sck_p_q;
  assign sck_fall = ~sck_s & sck_p_q;
  assign pass_u = (state_q == PASS_USER) & ~csb_rise;
  assign pass_m = (state_q == PASS_MGMT) & ~csb_rise;
  assign hk_sdo = sdo_q;
  assign hk_sdo_oe = oe_q;
  assign byte_data = sr_q;
  assign byte_valid = bv_q;
  assign byte_first = bf_q;
  assign user_csb = ucsb_q;
  assign user_sck = usck_q;
  assign user_io0 = uio_q;
  assign pass_active = pa_q;
`ifdef HKSPI_PASSTHRU_MGMT_EN
  logic mcsb_q, msck_q, mio_q;
  assign mgmt_in = mgmt_io1;
  assign mgmt_csb = mcsb_q;
  assign mgmt_sck = msck_q;
  assign mgmt_io0 = mio_q;
  assign mgmt_hold = pa_q[1];
  // mgmt flash pins mirror the user tunnel while in mgmt pass-thru
  always_ff @(posedge clock) begin
    if (reset) begin
      mcsb_q <= 1'b1;
      msck_q <= 1'b0;
      mio_q  <= 1'b0;
    end else begin
      mcsb_q <= ~pass_m;
      msck_q <= pass_m & gate_q & sck_s;
      mio_q  <= pass_m & sdi_s;
    end
  end
`else
  assign mgmt_in = 1'b0;
  assign mgmt_hold = 1'b0;
`endif
  // frame decode: command byte selects tunnel or register stage, CSB rise aborts from anywhere
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    bv_d = 1'b0;
    bf_d = 1'b0;
    if (csb_rise) begin
      state_d = IDLE;
      cnt_d = 3'd0;
    end else if (state_q == IDLE) begin
      if (csb_fall) begin
        state_d = CMD;
        cnt_d = 3'd0;
      end
    end else if (sck_rise && (state_q == CMD || state_q == HK)) begin
      sr_d = {sr_q[6:0], sdi_s};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        if (state_q == HK) bv_d = 1'b1;
        else if (sr_d == USER_CMD) state_d = PASS_USER;
        else if (MGMT_EN && sr_d == MGMT_CMD) state_d = PASS_MGMT;
        else begin
          state_d = HK;
          bv_d = 1'b1;
          bf_d = 1'b1;
        end
      end
    end
    oe_d = state_d == HK || state_d == PASS_USER || state_d == PASS_MGMT;
    gate_d = (state_q == PASS_USER || state_q == PASS_MGMT) & (gate_q | sck_fall);
    sdo_d = pass_u ? user_io1 : pass_m ? mgmt_in : state_q == HK ? (sck_fall ? reg_sdo : sdo_q) : 1'b0;
    pa_d = {pass_m, pass_u};
  end
  // synchronisers reset low so a CSB already low at reset cannot look like a fresh fall;
  // gate_q hides the SCK high left over from the command byte's last rise from the flash
  always_ff @(posedge clock) begin
    if (reset) begin
      csb_sync_q <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      csb_p_q <= 1'b0;
      sck_p_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= 3'd0;
      sr_q <= 8'd0;
      bv_q <= 1'b0;
      bf_q <= 1'b0;
      sdo_q <= 1'b0;
      oe_q <= 1'b0;
      gate_q <= 1'b0;
      ucsb_q <= 1'b1;
      usck_q <= 1'b0;
      uio_q <= 1'b0;
      pa_q <= 2'b00;
    end else begin
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], hk_csb};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], hk_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], hk_sdi};
      csb_p_q <= csb_s;
      sck_p_q <= sck_s;
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      bv_q <= bv_d;
      bf_q <= bf_d;
      sdo_q <= sdo_d;
      oe_q <= oe_d;
      gate_q <= gate_d;
      ucsb_q <= ~pass_u;
      usck_q <= pass_u & gate_q & sck_s;
      uio_q <= pass_u & sdi_s;
      pa_q <= pa_d;
    end
  end
endmodule

// File: tb/tb_hkspi_passthru_ctrl.sv
// tb_hkspi_passthru_ctrl: frame-level host/flash model with per-cycle output checks
module tb_hkspi_passthru_ctrl;
  localparam int H = 8;
`ifdef HKSPI_PASSTHRU_MGMT_EN
  localparam bit EN = 1'b1;
  logic mgmt_csb, mgmt_sck, mgmt_io0;
  logic mgmt_io1 = 1'b0;
`else
  localparam bit EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic hk_csb = 1'b1, hk_sck = 1'b0, hk_sdi = 1'b0, reg_sdo = 1'b0;
  logic hk_sdo, hk_sdo_oe, byte_valid, byte_first, user_csb, user_sck, user_io0, mgmt_hold;
  logic [7:0] byte_data;
  logic [1:0] pass_active;
  logic fio1 = 1'b0;
  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tx[$], rd[$], rx[$];
  logic [7:0] fb;
  logic [7:0] fmem[8] = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h93, 8'h01, 8'h00, 8'h00};
  int fcnt = 0, frises = 0;
  logic [7:0] fsh = 8'h00;
  logic [7:0] fseen[$];

  always #5 clock = ~clock;

  hkspi_passthru_ctrl dut (
    .clock(clock), .reset(reset), .hk_csb(hk_csb), .hk_sck(hk_sck), .hk_sdi(hk_sdi),
    .hk_sdo(hk_sdo), .hk_sdo_oe(hk_sdo_oe), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_first(byte_first), .reg_sdo(reg_sdo), .user_csb(user_csb), .user_sck(user_sck),
    .user_io0(user_io0), .user_io1(fio1),
`ifdef HKSPI_PASSTHRU_MGMT_EN
    .mgmt_csb(mgmt_csb), .mgmt_sck(mgmt_sck), .mgmt_io0(mgmt_io0), .mgmt_io1(mgmt_io1),
`endif
    .mgmt_hold(mgmt_hold), .pass_active(pass_active)
  );

  // SPI flash: records bytes clocked in, answers a read after 32 bits (cmd + 24-bit address)
  always @(posedge user_sck or posedge user_csb) begin
    if (user_csb) fcnt = 0;
    else begin
      fsh = {fsh[6:0], user_io0};
      fcnt++;
      frises++;
      if (fcnt % 8 == 0) fseen.push_back(fsh);
    end
  end
  always @(negedge user_sck)
    fio1 = (fcnt >= 32 && fcnt < 96) ? fmem[(fcnt - 32) / 8][7 - (fcnt - 32) % 8] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    if (byte_valid) begin
      if (byte_first) fb = byte_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got first=%0d data=%h, none expected at %0t", byte_first, byte_data, $time);
      end else check("byte", {23'd0, byte_first, byte_data}, {23'd0, exp_q.pop_front()});
    end
    check("inv_user_csb", user_csb, pass_active != 2'b01);
    check("inv_hold", mgmt_hold, pass_active == 2'b10);
    check("inv_oe", hk_sdo_oe || pass_active == 2'b00, 1);
    check("inv_user_idle", user_csb && (user_sck || user_io0), 0);
`ifndef HKSPI_PASSTHRU_MGMT_EN
    check("inv_no_mgmt", pass_active == 2'b10, 0);
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clock);
      sample();
    end
  endtask

  task automatic idle_sck(input int n);
    for (int i = 0; i < n; i++) begin
      hk_sck = 1'b1;
      cyc(H);
      hk_sck = 1'b0;
      cyc(H);
    end
  endtask

  // host frame from tx[], reg_sdo stream from rd[]; expectations derived from the command byte
  task automatic run_frame(input int nbits, input bit together, input int rst_at);
    logic [7:0] t, acc;
    bit up, mp, hk, alive;
    int eff, seen0, rises0;
    eff = together ? nbits - 1 : nbits;
    up = eff >= 8 && tx[0] == 8'hC2;
    mp = eff >= 8 && EN && tx[0] == 8'hC4;
    hk = eff >= 8 && !up && !mp;
    if (hk) for (int i = 0; i < eff / 8; i++) exp_q.push_back({i == 0, tx[i]});
    seen0 = fseen.size();
    rises0 = frises;
    alive = 1'b1;
    acc = 8'h00;
    rx.delete();
    fb = 8'h00;
    hk_csb = 1'b0;
    cyc(H);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        alive = 1'b0;
        check("rst_user_csb", user_csb, 1);
        check("rst_status", pass_active, 0);
      end
      t = tx[k / 8];
      hk_sdi = t[7 - k % 8];
      cyc(H);
      acc = {acc[6:0], hk_sdo};
      if (k % 8 == 7) rx.push_back(acc);
      if (k >= 8) begin
        check("user_csb", user_csb, !(alive && up));
        check("status", pass_active, alive ? {30'd0, mp, up} : 0);
        check("sdo_oe", hk_sdo_oe, alive && (up || mp || hk));
`ifdef HKSPI_PASSTHRU_MGMT_EN
        check("mgmt_csb", mgmt_csb, !(alive && mp));
`endif
      end else begin
        check("cmd_user_csb", user_csb, 1);
        check("cmd_status", pass_active, 0);
        check("cmd_sdo_oe", hk_sdo_oe, 0);
      end
      if (together && k == nbits - 1) begin
        hk_sck = 1'b1;
        hk_csb = 1'b1;
        cyc(H);
        hk_sck = 1'b0;
      end else begin
        hk_sck = 1'b1;
        t = (k + 1 < nbits) ? rd[(k + 1) / 8] : 8'h00;
        reg_sdo = t[7 - (k + 1) % 8];
        cyc(H);
        hk_sck = 1'b0;
      end
    end
    if (!together) begin
      cyc(H);
      hk_csb = 1'b1;
    end
    cyc(2 * H);
    check("pending_bytes", exp_q.size(), 0);
    exp_q.delete();
    check("end_user_csb", user_csb, 1);
    check("end_status", pass_active, 0);
    check("end_sdo_oe", hk_sdo_oe, 0);
    if (up && rst_at < 0) begin
      check("flash_rises", frises - rises0, eff - 8);
      check("flash_nbytes", fseen.size() - seen0, eff / 8 - 1);
      for (int i = 1; i < eff / 8 && seen0 + i - 1 < fseen.size(); i++)
        check("flash_byte", fseen[seen0 + i - 1], tx[i]);
    end
    if (hk) for (int i = 1; i < rx.size(); i++) check("hk_read", rx[i], rd[i]);
  endtask

  task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1);
    tx.delete();
    rd.delete();
    for (int i = 0; i < n; i++) begin
      tx.push_back(i == 0 ? b0 : i == 1 ? b1 : 8'h00);
      rd.push_back(8'h00);
    end
  endtask

  initial begin
    cyc(3);
    check("rst_user_csb0", user_csb, 1);
    check("rst_user_sck0", user_sck, 0);
    check("rst_user_io00", user_io0, 0);
    check("rst_hk_sdo", hk_sdo, 0);
    check("rst_hk_sdo_oe", hk_sdo_oe, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_first", byte_first, 0);
    check("rst_mgmt_hold", mgmt_hold, 0);
    check("rst_pass_active", pass_active, 0);
`ifdef HKSPI_PASSTHRU_MGMT_EN
    check("rst_mgmt_csb", mgmt_csb, 1);
    check("rst_mgmt_sck", mgmt_sck, 0);
`endif
    reset = 1'b0;
    cyc(4);
    load(3, 8'h40, 8'h03);
    rd[2] = 8'h11;
    run_frame(24, 1'b0, -1);
    check("t1_first_byte", fb, 8'h40);
    check("t1_read", rx.size() > 2 ? rx[2] : 8'hXX, 8'h11);
    load(13, 8'hC2, 8'h03);
    run_frame(104, 1'b0, -1);
    for (int i = 0; i < 8; i++) check("t2_flash_read", rx.size() > 5 + i ? rx[5 + i] : 8'hXX, fmem[i]);
    check("t2_read0", rx.size() > 5 ? rx[5] : 8'hXX, 8'h6F);
    check("t2_read4", rx.size() > 9 ? rx[9] : 8'hXX, 8'h93);
    load(2, 8'hC2, 8'hFF);
    run_frame(16, 1'b0, -1);
    load(2, 8'hC2, 8'hAB);
    run_frame(16, 1'b0, -1);
    check("t3_last_flash_byte", fseen.size() > 0 ? fseen[fseen.size() - 1] : 8'hXX, 8'hAB);
    load(1, 8'hC2, 8'h00);
    run_frame(5, 1'b0, -1);
    load(2, 8'h40, 8'h5A);
    run_frame(16, 1'b0, -1);
    check("t4_first_byte", fb, 8'h40);
    load(5, 8'hC2, 8'h03);
    run_frame(40, 1'b0, 20);
    load(2, 8'hC4, 8'h9F);
    run_frame(16, 1'b0, -1);
    check("t6_first_byte", fb, EN ? 8'h00 : 8'hC4);
    load(2, 8'h3C, 8'h77);
    run_frame(16, 1'b1, -1);
    idle_sck(5);
    load(2, 8'h40, 8'h55);
    run_frame(16, 1'b0, -1);
    check("idle_sck_first_byte", fb, 8'h40);
    for (int f = 0; f < 24; f++) begin
      int nb, nbits, sel;
      bit tog;
      sel = $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      tx.delete();
      rd.delete();
      for (int i = 0; i < nb; i++) begin
        tx.push_back(8'($urandom_range(0, 255)));
        rd.push_back(8'($urandom_range(0, 255)));
      end
      if (sel == 0) tx[0] = 8'hC2;
      if (sel == 1) tx[0] = 8'hC4;
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb * 8) : nb * 8;
      tog = nbits >= 16 && nbits % 8 == 0 && $urandom_range(0, 3) == 0;
      run_frame(nbits, tog, -1);
      if ($urandom_range(0, 3) == 0) idle_sck($urandom_range(1, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
